// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch controller:
// reset PC, FSM state encoding and the 65-bit downstream bus layout {adef, pc, inst}.
package if_fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC = 32'h1C00_0000;

    localparam int BUS_W    = 65;
    localparam int ADEF_BIT = 64;
    localparam int PC_HI    = 63;
    localparam int PC_LO    = 32;
    localparam int INST_HI  = 31;
    localparam int INST_LO  = 0;

    typedef logic [BUS_W-1:0] fetch_bus_t;

    typedef enum logic [1:0] {
        ST_REQ       = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_HOLD      = 2'd2
    } fetch_state_e;

    function automatic fetch_bus_t pack_bus(input logic adef, input logic [31:0] pc,
                                            input logic [31:0] inst);
        fetch_bus_t bus;
        bus                  = '0;
        bus[ADEF_BIT]        = adef;
        bus[PC_HI:PC_LO]     = pc;
        bus[INST_HI:INST_LO] = inst;
        return bus;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction SRAM request/response handshake. The fetch controller is the
// master (drives req/addr); the memory side is the slave.
interface if_fetch_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, addr, input addr_ok, data_ok, rdata);
    modport slave  (input req, addr, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: one outstanding SRAM request, redirect/cancel handling
// and a one-entry hold buffer. Optional performance counters under IF_PERF_CNT_EN.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              excep_flush_i,
    input  logic [31:0]       excep_pc_i,
    input  logic              branch_flush_i,
    input  logic [31:0]       branch_pc_i,
    input  logic              now_allowin_i,
    if_fetch_ctrl_if.master   inst_sram,
    output logic              line1_pre_to_now_valid_o,
    output logic [BUS_W-1:0]  pre_to_obus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt_o,
    output logic [31:0]       perf_drop_cnt_o
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         cancel_q, cancel_d;
    logic         req_hold_q, req_hold_d;
    logic [31:0]  req_addr_q, req_addr_d;
    fetch_bus_t   hold_buf_q, hold_buf_d;

    logic         flush;
    logic [31:0]  flush_pc;
    logic         adef_fetch;
    logic         take_resp;
    fetch_bus_t   resp_bus;

    assign flush    = excep_flush_i | branch_flush_i;
    assign flush_pc = excep_flush_i ? excep_pc_i : branch_pc_i;

    // A request redirected before acceptance keeps presenting its original address.
    assign adef_fetch     = (state_q == ST_REQ) && !req_hold_q && (fetch_pc_q[1:0] != 2'b00);
    assign inst_sram.req  = (state_q == ST_REQ) && !adef_fetch;
    assign inst_sram.addr = req_hold_q ? req_addr_q : fetch_pc_q;

    assign resp_bus = pack_bus(adef_fetch, fetch_pc_q, adef_fetch ? 32'h0 : inst_sram.rdata);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d                  = state_q;
        fetch_pc_d               = fetch_pc_q;
        cancel_d                 = cancel_q;
        req_hold_d               = req_hold_q;
        req_addr_d               = req_addr_q;
        hold_buf_d               = hold_buf_q;
        take_resp                = 1'b0;
        line1_pre_to_now_valid_o = 1'b0;
        pre_to_obus              = '0;

        case (state_q)
            ST_REQ: begin
                if (adef_fetch) begin
                    take_resp = 1'b1;
                end else begin
                    if (inst_sram.addr_ok) begin
                        state_d    = ST_WAIT_DATA;
                        req_hold_d = 1'b0;
                    end else if (flush && !req_hold_q) begin
                        req_hold_d = 1'b1;
                        req_addr_d = fetch_pc_q;
                    end
                    if (flush) cancel_d = 1'b1;
                end
            end
            ST_WAIT_DATA: begin
                if (inst_sram.data_ok) begin
                    if (cancel_q) begin
                        cancel_d = 1'b0;
                        state_d  = ST_REQ;
                    end else begin
                        take_resp = 1'b1;
                    end
                end else if (flush) begin
                    cancel_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    state_d = ST_REQ;
                end else begin
                    line1_pre_to_now_valid_o = 1'b1;
                    pre_to_obus              = hold_buf_q;
                    if (now_allowin_i) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = ST_REQ;
                    end
                end
            end
            default: state_d = ST_REQ;
        endcase

        // Live response: real SRAM data or a misaligned-PC fault with no request issued.
        if (take_resp) begin
            if (flush) begin
                state_d = ST_REQ;
            end else if (now_allowin_i) begin
                line1_pre_to_now_valid_o = 1'b1;
                pre_to_obus              = resp_bus;
                fetch_pc_d               = fetch_pc_q + 32'd4;
                state_d                  = ST_REQ;
            end else begin
                hold_buf_d = resp_bus;
                state_d    = ST_HOLD;
            end
        end

        if (flush) fetch_pc_d = flush_pc;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            cancel_q   <= 1'b0;
            req_hold_q <= 1'b0;
            req_addr_q <= RESET_PC;
            hold_buf_q <= '0;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            cancel_q   <= cancel_d;
            req_hold_q <= req_hold_d;
            req_addr_q <= req_addr_d;
            hold_buf_q <= hold_buf_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic        resp_seen;
    logic        fetch_evt;
    logic        drop_evt;
    logic [31:0] fetch_cnt_q;
    logic [31:0] drop_cnt_q;

    assign resp_seen = adef_fetch || ((state_q == ST_WAIT_DATA) && inst_sram.data_ok);
    assign fetch_evt = line1_pre_to_now_valid_o && now_allowin_i;
    assign drop_evt  = (resp_seen && (cancel_q || flush)) || ((state_q == ST_HOLD) && flush);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (fetch_evt) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (drop_evt)  drop_cnt_q  <= drop_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 rst_n  in  1  asynchronous, active-high reset (asserted = 1).
REQ-003 excep_flush_i  in  1  exception redirect; higher priority than branch_flush_i.
REQ-004 excep_pc_i  in  32  exception redirect target.
REQ-005 branch_flush_i  in  1  branch redirect.
REQ-006 branch_pc_i  in  32  branch redirect target.
REQ-007 now_allowin_i  in  1  downstream IF/ID register can accept this cycle.
REQ-008 inst_sram_req_o  out  1  fetch request.
REQ-009 inst_sram_addr_o  out  32  fetch address; stable while req_o=1 and addr_ok=0.
REQ-010 inst_sram_addr_ok_i  in  1  request accepted this cycle.
REQ-011 inst_sram_data_ok_i  in  1  read data returned this cycle.
REQ-012 inst_sram_rdata_i  in  32  read data.
REQ-013 line1_pre_to_now_valid_o  out  1  fetched instruction offered downstream.
REQ-014 pre_to_obus  out  65  {adef, pc[31:0], inst[31:0]}.

Function
REQ-015 States: REQ, WAIT_DATA, HOLD; at most one outstanding request.
REQ-016 REQ: req_o=1, addr_o=fetch_pc; addr_ok -> WAIT_DATA.
REQ-017 REQ with fetch_pc[1:0]!=0: req_o=0; treat as an immediate return with adef=1, inst=0, handled as a non-cancelled data_ok in REQ-019/020.
REQ-018 WAIT_DATA: req_o=0; wait for data_ok.
REQ-019 Non-cancelled data_ok with now_allowin_i=1: valid_o=1 same cycle, bus={0,fetch_pc,rdata}; fetch_pc+=4; -> REQ.
REQ-020 Non-cancelled data_ok with now_allowin_i=0: latch bus into a 65-bit hold buffer; -> HOLD; valid_o=0 that cycle.
REQ-021 HOLD: valid_o=1, bus=hold buffer; now_allowin_i=1 -> fetch_pc+=4, -> REQ.
REQ-022 Flush (either) forces valid_o=0 that cycle and fetch_pc<=target (excep_pc_i if excep_flush_i, else branch_pc_i).
REQ-023 Flush in REQ with addr_ok=0: req/addr held unchanged (latched request address), cancel<=1.
REQ-024 Flush in REQ with addr_ok=1, or in WAIT_DATA with data_ok=0: cancel<=1, state per REQ-016/018.
REQ-025 Flush in WAIT_DATA with data_ok=1: data dropped, cancel stays 0, -> REQ.
REQ-026 Flush in HOLD: buffer dropped, -> REQ.
REQ-027 data_ok with cancel=1: data dropped, cancel<=0, -> REQ with redirected fetch_pc; cancelled data never reaches valid_o.
REQ-028 Repeated flush while cancel=1: only fetch_pc updated; cancel remains 1 (one drop per outstanding request).
REQ-029 Once the held request is accepted after REQ-023, the next REQ issues the redirected fetch_pc.
REQ-030 fetch_pc arithmetic is 32-bit modulo; 0xFFFFFFFC+4 wraps to 0.

Reset
REQ-031 Reset values: state=REQ, fetch_pc=0x1C000000, cancel=0, hold buffer=0, valid_o=0, pre_to_obus=0, req_o=1 first cycle after release, addr_o=0x1C000000.
REQ-032 Reset mid-transaction discards any outstanding response; data_ok arriving during reset is ignored.

Configuration
REQ-033 Macro IF_PERF_CNT_EN: when defined, adds outputs perf_fetch_cnt_o[31:0] (increments per instruction accepted downstream) and perf_drop_cnt_o[31:0] (increments per cancelled/dropped response), both wrapping, reset to 0; when undefined, neither port nor counters exist and behaviour is otherwise identical.

Structure
REQ-034 Shared package/define file holds: reset PC, state encodings, bus width 65 and field offsets (adef bit 64, pc 63:32, inst 31:0).
REQ-035 Single flat module; the optional counters may form sub-module if_perf_cnt.

Verification
REQ-036 Reset release, addr_ok next cycle, data_ok 2 cycles later with rdata=0x02800000, allowin=1 -> valid_o=1, bus={0,0x1C000000,0x02800000}, next addr 0x1C000004.
REQ-037 data_ok with allowin=0 for 3 cycles -> valid_o=1 held with same bus, no new req until allowin=1.
REQ-038 branch_flush to 0x1C000100 in WAIT_DATA, data_ok 2 cycles later -> data dropped, valid_o stays 0, next req addr 0x1C000100, drop count +1 (with IF_PERF_CNT_EN).
REQ-039 Flush in REQ with addr_ok low for 2 cycles -> addr_o stays old address; response dropped; then req to target.
REQ-040 excep_flush (0x1C008000) and branch_flush (0x1C000200) same cycle -> next fetch at 0x1C008000.
REQ-041 branch_pc_i=0x1C000102 -> no req issued, valid_o=1 with adef=1, pc=0x1C000102, inst=0.
